// File: rtl/pci_bus_merge.sv
// Merges NUM_FUNC PCI function cores onto one set of pad drivers. The datapath is a zero-latency
// priority mux with per-bit hold, plus registered contention and turnaround monitoring.
module pci_bus_merge #(
  parameter int unsigned NUM_FUNC = 3,
  parameter int unsigned AD_WIDTH = 32,
  localparam int unsigned CBE_W = AD_WIDTH / 8,
  localparam int unsigned OWN_W = (NUM_FUNC > 1) ? $clog2(NUM_FUNC) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_FUNC*AD_WIDTH-1:0] f_ado_i,
  input  logic [NUM_FUNC*AD_WIDTH-1:0] f_adt_i,
  input  logic [NUM_FUNC*CBE_W-1:0]    f_cbo_i,
  input  logic [NUM_FUNC*CBE_W-1:0]    f_cbt_i,
  input  logic [NUM_FUNC*8-1:0]        f_ctlo_i,
  input  logic [NUM_FUNC*8-1:0]        f_ctlt_i,
  output logic [AD_WIDTH-1:0]          ado_o,
  output logic [AD_WIDTH-1:0]          adt_o,
  output logic [CBE_W-1:0]             cbo_o,
  output logic [CBE_W-1:0]             cbt_o,
  output logic [7:0]                   ctlo_o,
  output logic [7:0]                   ctlt_o,
  input  logic                         clr_err_i,
  output logic [9:0]                   contention_o,
  output logic [NUM_FUNC-1:0]          contention_func_o,
  output logic [15:0]                  contention_cnt_o,
  output logic [9:0]                   tar_viol_o,
  output logic                         ad_busy_o,
  output logic [OWN_W-1:0]             ad_owner_o
);

  localparam int unsigned TotW   = AD_WIDTH + CBE_W + 8;
  localparam int unsigned NumGrp = 10;

  typedef enum logic {StIdle, StOwned} trk_e;

  // All pad bits flattened as {ctl, cbe, ad}; group 0 = AD, 1 = CBE, 2..9 = ctl bits.
  function automatic logic [TotW-1:0] grp_mask(int unsigned g);
    logic [TotW-1:0] m;
    m = '0;
    if (g == 0)      m[AD_WIDTH-1:0]        = '1;
    else if (g == 1) m[AD_WIDTH +: CBE_W]   = '1;
    else             m[AD_WIDTH+CBE_W+g-2]  = 1'b1;
    return m;
  endfunction

  logic [NUM_FUNC-1:0][TotW-1:0]     fo, ft;
  logic [TotW-1:0]                   hold_q, mo, mt;
  logic [NumGrp-1:0][NUM_FUNC-1:0]   en;
  logic [NumGrp-1:0][OWN_W-1:0]      low_idx;
  logic [NumGrp-1:0]                 cont_now, viol;
  trk_e                              st_q [NumGrp];
  trk_e                              st_d [NumGrp];
  logic [NumGrp-1:0][OWN_W-1:0]      owner_q, owner_d;
  logic [9:0]                        cont_q, cont_d, cont_base, tar_q, tar_d;
  logic [NUM_FUNC-1:0]               func_q, func_d, func_cap;
  logic [15:0]                       cnt_q, cnt_d;

  always_comb begin
    for (int k = 0; k < int'(NUM_FUNC); k++) begin
      fo[k] = {f_ctlo_i[k*8 +: 8], f_cbo_i[k*CBE_W +: CBE_W], f_ado_i[k*AD_WIDTH +: AD_WIDTH]};
      ft[k] = {f_ctlt_i[k*8 +: 8], f_cbt_i[k*CBE_W +: CBE_W], f_adt_i[k*AD_WIDTH +: AD_WIDTH]};
    end
  end

  // Lowest-index driver wins; undriven bits replay the last driven value.
  always_comb begin
    mo = hold_q;
    mt = '1;
    for (int b = 0; b < int'(TotW); b++) begin
      for (int k = int'(NUM_FUNC) - 1; k >= 0; k--) begin
        if (!ft[k][b]) begin
          mo[b] = fo[k][b];
          mt[b] = 1'b0;
        end
      end
    end
  end

  assign ado_o  = mo[AD_WIDTH-1:0];
  assign adt_o  = mt[AD_WIDTH-1:0];
  assign cbo_o  = mo[AD_WIDTH +: CBE_W];
  assign cbt_o  = mt[AD_WIDTH +: CBE_W];
  assign ctlo_o = mo[AD_WIDTH+CBE_W +: 8];
  assign ctlt_o = mt[AD_WIDTH+CBE_W +: 8];

  always_comb begin
    int unsigned n;
    for (int g = 0; g < int'(NumGrp); g++) begin
      n          = 0;
      low_idx[g] = '0;
      for (int k = int'(NUM_FUNC) - 1; k >= 0; k--) begin
        en[g][k] = |(~ft[k] & grp_mask(g));
        if (en[g][k]) begin
          low_idx[g] = OWN_W'(k);
          n          = n + 1;
        end
      end
      cont_now[g] = (n >= 2);
    end
  end

  // Tracker state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < int'(NumGrp); g++) st_q[g] <= StIdle;
      owner_q <= '0;
    end else begin
      for (int g = 0; g < int'(NumGrp); g++) st_q[g] <= st_d[g];
      owner_q <= owner_d;
    end
  end

  // Tracker next state
  always_comb begin
    owner_d = owner_q;
    for (int g = 0; g < int'(NumGrp); g++) begin
      st_d[g] = st_q[g];
      if (en[g] == '0) begin
        st_d[g]    = StIdle;
        owner_d[g] = '0;
      end else begin
        unique case (st_q[g])
          StIdle: begin
            st_d[g]    = StOwned;
            owner_d[g] = low_idx[g];
          end
          StOwned: begin
            if (!en[g][owner_q[g]]) owner_d[g] = low_idx[g];
          end
          default: st_d[g] = StIdle;
        endcase
      end
    end
  end

  // Tracker outputs: a hand-over without an idle cycle is a turnaround violation
  always_comb begin
    viol = '0;
    for (int g = 0; g < int'(NumGrp); g++) begin
      viol[g] = (st_q[g] == StOwned) && (en[g] != '0) && !en[g][owner_q[g]];
    end
    ad_busy_o  = (st_q[0] == StOwned);
    ad_owner_o = owner_q[0];
  end

  // Sticky status: an event coinciding with clr_err survives the clear.
  always_comb begin
    cont_base = clr_err_i ? '0 : cont_q;
    cont_d    = cont_base | cont_now;
    tar_d     = (clr_err_i ? '0 : tar_q) | viol;
    cnt_d     = clr_err_i ? '0 : cnt_q;
    if (|cont_now && cnt_d != 16'hFFFF) cnt_d = cnt_d + 16'd1;
    func_cap = '0;
    for (int g = int'(NumGrp) - 1; g >= 0; g--) begin
      if (cont_now[g]) func_cap = en[g];
    end
    func_d = clr_err_i ? '0 : func_q;
    if (|cont_now && cont_base == '0) func_d = func_cap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      cont_q <= '0;
      tar_q  <= '0;
      cnt_q  <= '0;
      func_q <= '0;
    end else begin
      hold_q <= mo;
      cont_q <= cont_d;
      tar_q  <= tar_d;
      cnt_q  <= cnt_d;
      func_q <= func_d;
    end
  end

  assign contention_o      = cont_q;
  assign contention_func_o = func_q;
  assign contention_cnt_o  = cnt_q;
  assign tar_viol_o        = tar_q;

endmodule

// File: tb/tb_pci_bus_merge.sv
// Bench for pci_bus_merge: directed scenarios plus random traffic, all compared against a
// behavioural model of the merge rules, contention counters and bus-owner trackers.
module tb_pci_bus_merge;
  localparam int NF = 3, AW = 32, CW = 4, TW = AW + CW + 8, NG = 10, OW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NF*AW-1:0] f_ado, f_adt;
  logic [NF*CW-1:0] f_cbo, f_cbt;
  logic [NF*8-1:0]  f_ctlo, f_ctlt;
  logic             clr_err;
  logic [AW-1:0]    ado, adt;
  logic [CW-1:0]    cbo, cbt;
  logic [7:0]       ctlo, ctlt;
  logic [9:0]       contention, tar_viol;
  logic [NF-1:0]    contention_func;
  logic [15:0]      contention_cnt;
  logic             ad_busy;
  logic [OW-1:0]    ad_owner;

  pci_bus_merge #(.NUM_FUNC(NF), .AD_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_ado_i(f_ado), .f_adt_i(f_adt), .f_cbo_i(f_cbo), .f_cbt_i(f_cbt),
    .f_ctlo_i(f_ctlo), .f_ctlt_i(f_ctlt),
    .ado_o(ado), .adt_o(adt), .cbo_o(cbo), .cbt_o(cbt), .ctlo_o(ctlo), .ctlt_o(ctlt),
    .clr_err_i(clr_err), .contention_o(contention), .contention_func_o(contention_func),
    .contention_cnt_o(contention_cnt), .tar_viol_o(tar_viol),
    .ad_busy_o(ad_busy), .ad_owner_o(ad_owner)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [TW-1:0] m_hold, e_o, e_t;
  logic [9:0]    m_cont, m_tar;
  logic [NF-1:0] m_func;
  int            m_cnt;
  int            m_own [NG];  // -1 = nobody owned the group last cycle

  function automatic logic fo_bit(int k, int b);
    if (b < AW) return f_ado[k*AW+b];
    if (b < AW + CW) return f_cbo[k*CW+b-AW];
    return f_ctlo[k*8+b-AW-CW];
  endfunction

  function automatic logic ft_bit(int k, int b);
    if (b < AW) return f_adt[k*AW+b];
    if (b < AW + CW) return f_cbt[k*CW+b-AW];
    return f_ctlt[k*8+b-AW-CW];
  endfunction

  function automatic int grp_of(int b);
    if (b < AW) return 0;
    if (b < AW + CW) return 1;
    return 2 + b - AW - CW;
  endfunction

  task automatic model_reset();
    m_hold = '0; m_cont = '0; m_tar = '0; m_func = '0; m_cnt = 0;
    for (int g = 0; g < NG; g++) m_own[g] = -1;
  endtask

  task automatic compute_comb();
    for (int b = 0; b < TW; b++) begin
      e_o[b] = m_hold[b];
      e_t[b] = 1'b1;
      for (int k = 0; k < NF; k++) begin
        if (!ft_bit(k, b)) begin
          e_o[b] = fo_bit(k, b);
          e_t[b] = 1'b0;
          break;
        end
      end
    end
  endtask

  task automatic model_step();
    logic [NF-1:0] enm [NG];
    int  users, low, first;
    compute_comb();
    m_hold = e_o;
    for (int g = 0; g < NG; g++) enm[g] = '0;
    for (int b = 0; b < TW; b++)
      for (int k = 0; k < NF; k++)
        if (!ft_bit(k, b)) enm[grp_of(b)][k] = 1'b1;
    if (clr_err) begin
      m_cont = '0; m_tar = '0; m_func = '0; m_cnt = 0;
    end
    first = -1;
    for (int g = 0; g < NG; g++) begin
      users = $countones(enm[g]);
      low = -1;
      for (int k = NF - 1; k >= 0; k--) if (enm[g][k]) low = k;
      if (users >= 2 && first < 0) first = g;
      if (users == 0) m_own[g] = -1;
      else if (m_own[g] < 0) m_own[g] = low;
      else if (!enm[g][m_own[g]]) begin
        m_tar[g] = 1'b1;
        m_own[g] = low;
      end
    end
    if (first >= 0) begin
      if (m_cont == '0) m_func = enm[first];
      for (int g = 0; g < NG; g++) if ($countones(enm[g]) >= 2) m_cont[g] = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic check_comb();
    compute_comb();
    check("merged_out", {ctlo, cbo, ado}, e_o);
    check("merged_tri", {ctlt, cbt, adt}, e_t);
  endtask

  task automatic check_status();
    check("contention", contention, m_cont);
    check("cont_func", contention_func, m_func);
    check("cont_cnt", contention_cnt, m_cnt);
    check("tar_viol", tar_viol, m_tar);
    check("ad_busy", ad_busy, m_own[0] >= 0);
    check("ad_owner", ad_owner, (m_own[0] >= 0) ? m_own[0] : 0);
  endtask

  // Inputs are driven just after the edge; outputs checked mid-cycle and after the next edge.
  task automatic tick(input bit chk);
    #1;
    if (chk) check_comb();
    model_step();
    @(posedge clk);
    #1;
    if (chk) check_status();
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic release_all();
    f_adt = '1; f_cbt = '1; f_ctlt = '1;
  endtask

  task automatic set_ad(input int k, input logic [AW-1:0] v);
    f_ado[k*AW +: AW] = v; f_adt[k*AW +: AW] = '0;
  endtask

  task automatic set_cb(input int k, input logic [CW-1:0] v);
    f_cbo[k*CW +: CW] = v; f_cbt[k*CW +: CW] = '0;
  endtask

  task automatic set_ctl(input int k, input int i, input logic v);
    f_ctlo[k*8+i] = v; f_ctlt[k*8+i] = 1'b0;
  endtask

  task automatic do_clear();
    release_all(); clr_err = 1'b1; tick(1); clr_err = 1'b0;
  endtask

  initial begin
    f_ado = '0; f_cbo = '0; f_ctlo = '0; clr_err = 1'b0;
    release_all();
    model_reset();
    #12;
    check("rst_adt", adt, 32'hFFFF_FFFF);
    check("rst_ado", ado, 32'h0);
    check_status();
    @(posedge clk); #1 rst_n = 1'b1;

    // F1 drives AD for two cycles then releases
    set_ad(1, 32'hA5A5_1234);
    #1 check("s1_ado_live", ado, 32'hA5A5_1234);
    tick(1);
    check("s1_owner", ad_owner, 1); check("s1_busy", ad_busy, 1);
    tick(1);
    check("s1_owner2", ad_owner, 1); check("s1_busy2", ad_busy, 1);
    release_all();
    #1 check("s1_hold", ado, 32'hA5A5_1234);
    check("s1_adt_rel", adt, 32'hFFFF_FFFF);
    tick(1);
    check("s1_idle", ad_busy, 0); check("s1_noflag", {contention, tar_viol}, 0);

    // F0 and F2 fight over devsel
    set_ctl(0, 5, 1'b0); set_ctl(2, 5, 1'b1);
    #1 check("s2_devsel", ctlo[5], 0);
    tick(1);
    check("s2_cont", contention, 10'h080);
    check("s2_func", contention_func, 3'b101);
    check("s2_cnt1", contention_cnt, 1);
    repeat (5) tick(1);
    check("s2_cnt6", contention_cnt, 6);
    do_clear();

    // Back-to-back AD owners, then with an idle gap
    set_ad(0, 32'h1111_0000); tick(1);
    release_all(); set_ad(1, 32'h2222_0000); tick(1);
    check("s3_viol", tar_viol[0], 1); check("s3_owner", ad_owner, 1);
    do_clear();
    set_ad(0, 32'h3333_0000); tick(1);
    release_all(); tick(1);
    set_ad(1, 32'h4444_0000); tick(1);
    check("s3_noviol", tar_viol, 0); check("s3_owner_gap", ad_owner, 1);
    release_all(); tick(1);

    // Clear coinciding with a new CBE contention
    clr_err = 1'b1; set_cb(0, 4'h3); set_cb(2, 4'hC); tick(1);
    clr_err = 1'b0;
    check("s4_cont", contention, 10'h002);
    check("s4_cnt", contention_cnt, 1);
    check("s4_tar", tar_viol, 0);
    release_all(); tick(1);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      release_all();
      f_ado = {$urandom, $urandom, $urandom};
      f_cbo = 12'($urandom); f_ctlo = 24'($urandom);
      for (int k = 0; k < NF; k++) begin
        if ($urandom_range(0, 99) < 25) f_adt[k*AW +: AW] = $urandom & $urandom;
        if ($urandom_range(0, 99) < 25) f_cbt[k*CW +: CW] = 4'($urandom);
        for (int i = 0; i < 8; i++)
          if ($urandom_range(0, 99) < 15) f_ctlt[k*8+i] = 1'b0;
      end
      clr_err = ($urandom_range(0, 19) == 0);
      tick(1);
    end
    clr_err = 1'b0;
    do_clear();

    // Counter saturation, then asynchronous reset mid-burst
    set_ad(0, 32'hDEAD_BEEF); set_ad(1, 32'h0BAD_F00D);
    repeat (70000) tick(0);
    check("sat_cnt", contention_cnt, 16'hFFFF);
    check_status();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_cont", contention, 0);
    check("arst_cnt", contention_cnt, 0);
    check("arst_func", contention_func, 0);
    check("arst_busy", ad_busy, 0);
    check("arst_ado_live", ado, 32'hDEAD_BEEF);
    check_status();
    @(posedge clk); #1 rst_n = 1'b1;
    release_all();
    repeat (3) tick(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
